// File: rtl/srv_defs.sv
// Shared front-end types and default sizing for the instruction fetch queue.
package srv_defs;

    // One fetched instruction as it travels from fetch to decode/issue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic        fetch_fault;
    } ifq_ent_t;

    localparam int unsigned IFQ_ENTRIES = 8;
    localparam int unsigned IFQ_IN_W    = 2;
    localparam int unsigned IFQ_OUT_W   = 2;

endpackage

// File: rtl/ifq_compact.sv
// Valid-mask compaction: destination offset of every lane (number of valid
// lanes below it) plus the total number of valid lanes.
module ifq_compact #(
    parameter int unsigned IN_W = 2
) (
    input  logic [IN_W-1:0]                      valid,
    output logic [IN_W-1:0][$clog2(IN_W+1)-1:0]  offset,
    output logic [$clog2(IN_W+1)-1:0]            total
);

    localparam int unsigned OW = $clog2(IN_W + 1);

    logic [OW-1:0] acc;

    // Running prefix count over the lanes, oldest lane first.
    always_comb begin
        acc    = '0;
        offset = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            offset[i] = acc;
            acc       = acc + OW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: per-instruction circular buffer between fetch and
// decode/issue, with empty-queue bypass, flush, occupancy and almost-full.
module ifq
    import srv_defs::*;
#(
    parameter int unsigned ENTRIES   = IFQ_ENTRIES,
    parameter int unsigned IN_W      = IFQ_IN_W,
    parameter int unsigned OUT_W     = IFQ_OUT_W,
    parameter int unsigned AFULL_LVL = ENTRIES - IN_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [IN_W-1:0]              in_valid,
    input  ifq_ent_t [IN_W-1:0]          in_inst,
    output logic                         in_ready,
    output logic [OUT_W-1:0]             out_valid,
    output ifq_ent_t [OUT_W-1:0]         out_inst,
    input  logic [$clog2(OUT_W+1)-1:0]   out_take,
    output logic [$clog2(ENTRIES+1)-1:0] count,
    output logic                         full,
    output logic                         afull
);

    localparam int unsigned PW = $clog2(ENTRIES);
    localparam int unsigned CW = $clog2(ENTRIES + 1);
    localparam int unsigned OW = $clog2(IN_W + 1);

    ifq_ent_t            mem [ENTRIES];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [IN_W-1:0][OW-1:0] offset;
    logic [OW-1:0]       n_valid;
    logic [OW-1:0]       n_push;
    logic                push_en;
    ifq_ent_t [IN_W-1:0] comp;
    int unsigned         avail;

    ifq_compact #(.IN_W(IN_W)) u_compact (
        .valid  (in_valid),
        .offset (offset),
        .total  (n_valid)
    );

    assign in_ready = (ENTRIES - 32'(count)) >= IN_W;
    assign push_en  = in_ready & ~flush;
    assign n_push   = push_en ? n_valid : '0;
    assign full     = 32'(count) == ENTRIES;
    assign afull    = 32'(count) >= AFULL_LVL;

    // Squeeze the valid input lanes together so lane order is preserved.
    always_comb begin
        comp = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            for (int unsigned j = 0; j < IN_W; j++) begin
                if (in_valid[i] && offset[i] == OW'(j)) begin
                    comp[j] = in_inst[i];
                end
            end
        end
    end

    // Oldest-first view: stored entries followed by the acceptable input group.
    always_comb begin
        avail     = 32'(count) + (in_ready ? 32'(n_valid) : 0);
        out_valid = '0;
        out_inst  = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            out_valid[k] = ~flush && (avail > k);
            if (k < 32'(count)) begin
                out_inst[k] = mem[rptr + PW'(k)];
            end else begin
                for (int unsigned j = 0; j < IN_W; j++) begin
                    if (k - 32'(count) == j) begin
                        out_inst[k] = comp[j];
                    end
                end
            end
        end
    end

    // Every pushed lane is written, even if bypassed this cycle; rptr then
    // advances by the full take, which keeps count and ordering identical.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= wptr;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(n_push);
            rptr  <= rptr + PW'(out_take);
            count <= CW'(32'(count) + 32'(n_push) - 32'(out_take));
        end
    end

    // Slot storage; compacted group wraps naturally through the pointer width.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int unsigned i = 0; i < IN_W; i++) begin
                if (in_valid[i]) begin
                    mem[wptr + PW'(offset[i])] <= in_inst[i];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A flush cycle hides the view, so take is only meaningful outside it.
    a_take_legal: assert property (@(posedge clk) disable iff (!rst_n)
        flush || (32'(out_take) <= 32'($countones(out_valid))));
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        32'(count) <= ENTRIES);
    a_thermo: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid & (out_valid + 1'b1)) == '0);
`endif

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: queue-based reference model plus directed
// literal checks.
module tb_ifq;
    import srv_defs::*;

    localparam int unsigned ENTRIES   = 8;
    localparam int unsigned IN_W      = 2;
    localparam int unsigned OUT_W     = 2;
    localparam int unsigned AFULL_LVL = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [IN_W-1:0]     in_valid;
    ifq_ent_t [IN_W-1:0] in_inst;
    logic                in_ready;
    logic [OUT_W-1:0]    out_valid;
    ifq_ent_t [OUT_W-1:0] out_inst;
    logic [1:0]          out_take;
    logic [3:0]          count;
    logic                full;
    logic                afull;

    int n_chk  = 0;
    int n_fail = 0;

    ifq_ent_t q[$];

    ifq #(
        .ENTRIES   (ENTRIES),
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_take  (out_take),
        .count     (count),
        .full      (full),
        .afull     (afull)
    );

    always #5 clk = ~clk;

    function automatic ifq_ent_t mk(input int unsigned id);
        ifq_ent_t e;
        e.pc          = 32'h0000_1000 + id * 4;
        e.inst        = 32'hA000_0000 | id;
        e.pred_taken  = id[0];
        e.fetch_fault = id[1];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input int unsigned a0, input int unsigned a1,
                         input logic [1:0] t, input logic f);
        in_valid   = v;
        in_inst[0] = mk(a0);
        in_inst[1] = mk(a1);
        out_take   = t;
        flush      = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of instructions updated at each clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (ENTRIES - q.size() >= IN_W) begin
                    for (int i = 0; i < IN_W; i++) begin
                        if (in_valid[i]) q.push_back(in_inst[i]);
                    end
                end
                for (int i = 0; i < int'(out_take); i++) begin
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    initial begin
        ifq_ent_t view[$];
        logic     ev;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                view = q;
                if (ENTRIES - q.size() >= IN_W) begin
                    for (int i = 0; i < IN_W; i++) begin
                        if (in_valid[i]) view.push_back(in_inst[i]);
                    end
                end
                for (int k = 0; k < OUT_W; k++) begin
                    ev = !flush && (view.size() > k);
                    chk($sformatf("mdl_out_valid%0d", k), 128'(out_valid[k]), 128'(ev));
                    if (ev) chk($sformatf("mdl_out_inst%0d", k), 128'(out_inst[k]), 128'(view[k]));
                end
                chk("mdl_count", 128'(count), 128'(q.size()));
                chk("mdl_full", 128'(full), 128'(q.size() == ENTRIES));
                chk("mdl_afull", 128'(afull), 128'(q.size() >= AFULL_LVL));
                chk("mdl_in_ready", 128'(in_ready), 128'(ENTRIES - q.size() >= IN_W));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(2'b00));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_afull", 128'(afull), 128'(0));

        // Full bypass while empty
        drive(2'b11, 1, 2, 2'd2, 1'b0);
        #1;
        chk("byp_valid", 128'(out_valid), 128'(2'b11));
        chk("byp_inst0", 128'(out_inst[0]), 128'(mk(1)));
        chk("byp_inst1", 128'(out_inst[1]), 128'(mk(2)));
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("byp_count", 128'(count), 128'(0));

        // Partial bypass: lane 1 stays behind
        drive(2'b11, 3, 4, 2'd1, 1'b0);
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("pbyp_count", 128'(count), 128'(1));
        chk("pbyp_inst0", 128'(out_inst[0]), 128'(mk(4)));
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        tick();

        // Hole in the fetch group, then single-lane issue
        drive(2'b10, 9, 10, 2'd0, 1'b0);
        tick();
        drive(2'b11, 11, 12, 2'd1, 1'b0);
        #1;
        chk("hole_count1", 128'(count), 128'(1));
        chk("hole_inst0a", 128'(out_inst[0]), 128'(mk(10)));
        chk("hole_inst1a", 128'(out_inst[1]), 128'(mk(11)));
        tick();
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        #1;
        chk("hole_count2", 128'(count), 128'(2));
        chk("hole_inst0b", 128'(out_inst[0]), 128'(mk(11)));
        tick();
        #1;
        chk("hole_count3", 128'(count), 128'(1));
        chk("hole_inst0c", 128'(out_inst[0]), 128'(mk(12)));
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("hole_count4", 128'(count), 128'(0));

        // Fill to full, blocked push, then wrap
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 20 + 2 * i, 21 + 2 * i, 2'd0, 1'b0);
            tick();
        end
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("full_count", 128'(count), 128'(8));
        chk("full_flag", 128'(full), 128'(1));
        chk("full_in_ready", 128'(in_ready), 128'(0));
        chk("full_afull", 128'(afull), 128'(1));
        drive(2'b11, 28, 29, 2'd1, 1'b0);
        #1;
        chk("full_inst0", 128'(out_inst[0]), 128'(mk(20)));
        tick();
        chk("held_count7", 128'(count), 128'(7));
        chk("held_in_ready", 128'(in_ready), 128'(0));
        tick();
        chk("held_count6", 128'(count), 128'(6));
        chk("held_in_ready1", 128'(in_ready), 128'(1));
        drive(2'b11, 28, 29, 2'd0, 1'b0);
        tick();
        drive(2'b00, 0, 0, 2'd2, 1'b0);
        #1;
        chk("wrap_count", 128'(count), 128'(8));
        chk("wrap_inst0", 128'(out_inst[0]), 128'(mk(22)));
        for (int i = 0; i < 3; i++) tick();
        chk("wrap_last1", 128'(out_inst[1]), 128'(mk(29)));
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("drain_count", 128'(count), 128'(0));

        // Almost-full threshold
        drive(2'b11, 30, 31, 2'd0, 1'b0);
        tick();
        drive(2'b11, 32, 33, 2'd0, 1'b0);
        tick();
        drive(2'b10, 0, 34, 2'd0, 1'b0);
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("af_count5", 128'(count), 128'(5));
        chk("af_off5", 128'(afull), 128'(0));
        drive(2'b01, 35, 0, 2'd0, 1'b0);
        tick();
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        #1;
        chk("af_count6", 128'(count), 128'(6));
        chk("af_on6", 128'(afull), 128'(1));
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("af_off_again", 128'(afull), 128'(0));

        // Flush overrides push and take
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        tick();
        drive(2'b11, 40, 41, 2'd2, 1'b1);
        #1;
        chk("fl_count4", 128'(count), 128'(4));
        chk("fl_out_valid", 128'(out_valid), 128'(2'b00));
        chk("fl_in_ready", 128'(in_ready), 128'(1));
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("fl_count0", 128'(count), 128'(0));
        chk("fl_empty", 128'(out_valid), 128'(2'b00));
        tick();

        // Asynchronous reset mid-stream
        drive(2'b11, 50, 51, 2'd0, 1'b0);
        tick();
        drive(2'b11, 52, 53, 2'd0, 1'b0);
        tick();
        drive(2'b01, 54, 0, 2'd0, 1'b0);
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("ar_count5", 128'(count), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("ar_count0", 128'(count), 128'(0));
        chk("ar_full", 128'(full), 128'(0));
        chk("ar_afull", 128'(afull), 128'(0));
        chk("ar_out_valid", 128'(out_valid), 128'(2'b00));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", 128'(in_ready), 128'(1));
        drive(2'b11, 60, 61, 2'd1, 1'b0);
        tick();
        drive(2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("post_rst_inst0", 128'(out_inst[0]), 128'(mk(61)));
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
